axil_regfile_slave: RTL and testbench
=====================================

// Module: axil_regfile_slave
// PURPOSE
//  Parametrised AXI4-Lite slave register file. Successor to the fixed 4-register / 4-bit-address slave.
//  Sits behind an AXI-Lite master. Exposes NUM_REGS read/write registers to user logic.
//  Accepts AW and W independently, decodes out-of-range accesses to SLVERR, and supports back-pressure on B/R.
// PARAMETERS
//  ADDR_W    default 8   byte-address width of AWADDR/ARADDR
//  DATA_W    default 32  data width; 32 or 64 only
//  NUM_REGS  default 16  number of registers; 1..2**(ADDR_W-LSB), where LSB = $clog2(DATA_W/8)
// PORTS
//  ACLK     in   1              single clock; all logic on rising edge
//  ARESETn  in   1              asynchronous, active-low reset
//  AWADDR   in   ADDR_W         write address
//  AWVALID  in   1              write-address valid
//  AWREADY  out  1              write-address ready
//  WDATA    in   DATA_W         write data
//  WSTRB    in   DATA_W/8       byte strobes (see CONFIGURATION)
//  WVALID   in   1              write-data valid
//  WREADY   out  1              write-data ready
//  BRESP    out  2              write response: 00 OKAY, 10 SLVERR
//  BVALID   out  1              write-response valid
//  BREADY   in   1              write-response ready
//  ARADDR   in   ADDR_W         read address
//  ARVALID  in   1              read-address valid
//  ARREADY  out  1              read-address ready
//  RDATA    out  DATA_W         read data
//  RRESP    out  2              read response: 00 OKAY, 10 SLVERR
//  RVALID   out  1              read-data valid
//  RREADY   in   1              read-data ready
//  reg_q    out  NUM_REGS*DATA_W  all register contents; reg i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset (async, ARESETn=0):
//   - Outputs: AWREADY=1, WREADY=1, ARREADY=1; BVALID=0, RVALID=0; BRESP=RRESP=00; RDATA=0.
//   - All registers 0. Holding buffers empty.
//   - Reset mid-transaction drops all pending AW/W/B/R state; no partial write occurs.
//  Addressing:
//   - index = ADDR[ADDR_W-1:LSB]; ADDR[LSB-1:0] ignored.
//   - index >= NUM_REGS -> SLVERR. SLVERR writes modify nothing; SLVERR reads return RDATA=0.
//  Write path:
//   - AW and W are each captured into a one-entry holding buffer on VALID&&READY.
//   - AWREADY = !aw_held; WREADY = !w_held. Either may arrive first, or both in the same cycle.
//   - Commit happens in the cycle where both are held and (!BVALID || BREADY). In that cycle:
//     - the register updates;
//     - both buffers clear;
//     - BVALID is set.
//   - Latency: AW+W handshake in cycle N -> register updated and BVALID=1 visible in cycle N+1.
//   - BVALID/BRESP held stable until BREADY. A new AW/W may be captured while B is pending.
//  Read path:
//   - ARREADY = !RVALID || RREADY (single-entry read pipeline, no bubble on back-to-back reads).
//   - AR handshake in cycle N -> RVALID=1 with RDATA/RRESP in cycle N+1.
//   - RDATA/RRESP held stable while RVALID && !RREADY.
//  Simultaneous events:
//   - Read and write to the same register on the same edge: read returns the pre-write value.
//   - Read and write channels are fully independent; no arbitration.
//  Protocol: VALID-before-READY dependency honoured; outputs never depend combinationally on the same-channel VALID.
// CONFIGURATION
//  AXIL_WSTRB_EN
//   - defined: byte lane b of the target register is written only when WSTRB[b]=1. WSTRB=0 is a valid no-op write and returns OKAY.
//   - undefined: WSTRB is ignored and every accepted write updates the full DATA_W.
// STRUCTURE
//  Package axil_pkg:
//   - resp_e enum {OKAY=2'b00, SLVERR=2'b10}
//   - DATA_W/8 strobe-width function
//   - default-parameter localparams
//  Sub-module axil_reg_bank (storage + byte-enable write + read mux, NUM_REGS x DATA_W).
//   - Top level keeps the channel handshakes and holding buffers.
// TESTING
//  1. Reset -> AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, reg_q all 0.
//  2. AW(0x08) and W(0xDEADBEEF, WSTRB=F) same cycle -> BVALID next cycle, BRESP=00;
//     then read 0x08 -> RDATA=0xDEADBEEF, RRESP=00.
//  3. W(0x12345678) three cycles before AW(0x04) -> WREADY=0 until commit; reg1=0x12345678 one cycle after AW handshake.
//  4. Write to 0x40 with NUM_REGS=16 -> BRESP=10, reg_q unchanged;
//     read 0x40 -> RRESP=10, RDATA=0.
//  5. BREADY=0 for 5 cycles after a write -> BVALID/BRESP stable; next AW/W captured but not committed until BREADY=1.
//     RREADY=0 likewise holds RDATA.
//  6. AXIL_WSTRB_EN: reg2=0xFFFFFFFF, write 0x00000000 with WSTRB=4'b0101 -> reg2=0xFF00FF00;
//     without the macro -> reg2=0x00000000.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types and defaults for the AXI4-Lite register file slave.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  localparam int AXIL_ADDR_W   = 8;
  localparam int AXIL_DATA_W   = 32;
  localparam int AXIL_NUM_REGS = 16;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Register storage with byte-enable writes, an index read mux and a flat view of every register.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int DATA_W   = AXIL_DATA_W,
  parameter int NUM_REGS = AXIL_NUM_REGS,
  parameter int IDX_W    = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [IDX_W-1:0]           widx_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        wbe_i,
  input  logic [IDX_W-1:0]           ridx_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int STRB_W = strb_width(DATA_W);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      mem_d[r] = mem_q[r];
      if (we_i && (widx_i == IDX_W'(r))) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wbe_i[b]) mem_d[r][b*8 +: 8] = wdata_i[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= mem_d[r];
    end
  end

  // Indices beyond NUM_REGS fall through to zero.
  always_comb begin
    rdata_o = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (ridx_i == IDX_W'(r)) rdata_o = mem_q[r];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = mem_q[g];
  end

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave exposing NUM_REGS registers; AW/W held independently, SLVERR on out-of-range index.
// Optional macro AXIL_WSTRB_EN enables per-byte write strobes (otherwise WSTRB is ignored).
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int ADDR_W   = AXIL_ADDR_W,
  parameter int DATA_W   = AXIL_DATA_W,
  parameter int NUM_REGS = AXIL_NUM_REGS
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [DATA_W/8-1:0]        WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_q
);

  localparam int STRB_W = strb_width(DATA_W);
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  logic              aw_held_q, aw_held_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic              w_held_q, w_held_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              bvalid_q, bvalid_d;
  resp_e             bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  resp_e             rresp_q, rresp_d;

  logic              aw_hs, w_hs, ar_hs, commit, wr_err, rd_err;
  logic [IDX_W-1:0]  aw_idx_cur, ar_idx;
  logic [DATA_W-1:0] w_data_cur, bank_rdata;
  logic [STRB_W-1:0] wbe;
  logic              unused_addr_lsb;

  assign AWREADY = !aw_held_q;
  assign WREADY  = !w_held_q;
  assign ARREADY = !rvalid_q || RREADY;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  assign unused_addr_lsb = ^{AWADDR[LSB-1:0], ARADDR[LSB-1:0]};

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // A channel arriving this cycle is used directly so commit lands on the handshake edge.
  assign aw_idx_cur = aw_held_q ? aw_idx_q : AWADDR[ADDR_W-1:LSB];
  assign w_data_cur = w_held_q ? w_data_q : WDATA;
  assign commit     = (aw_held_q || aw_hs) && (w_held_q || w_hs) && (!bvalid_q || BREADY);
  assign wr_err     = !idx_in_range(aw_idx_cur);
  assign ar_idx     = ARADDR[ADDR_W-1:LSB];
  assign rd_err     = !idx_in_range(ar_idx);

`ifdef AXIL_WSTRB_EN
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  assign wbe = w_held_q ? w_strb_q : WSTRB;

  always_comb begin
    w_strb_d = w_strb_q;
    if (!commit && w_hs) w_strb_d = WSTRB;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_strb_q <= '0;
    else          w_strb_q <= w_strb_d;
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^WSTRB;
  assign wbe          = '1;
`endif

  axil_reg_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk_i   (ACLK),
    .rst_ni  (ARESETn),
    .we_i    (commit && !wr_err),
    .widx_i  (aw_idx_cur),
    .wdata_i (w_data_cur),
    .wbe_i   (wbe),
    .ridx_i  (ar_idx),
    .rdata_o (bank_rdata),
    .regs_o  (reg_q)
  );

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_err ? SLVERR : OKAY;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_idx_d  = AWADDR[ADDR_W-1:LSB];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = WDATA;
      end
      if (BREADY) bvalid_d = 1'b0;
    end

    // Bank read sees pre-write contents, so a same-edge write is not visible here.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_err ? '0 : bank_rdata;
      rresp_d  = rd_err ? SLVERR : OKAY;
    end else if (RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Randomized self-checking bench for axil_regfile_slave against an array-based register model.
module tb_axil_regfile_slave;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  logic                       ACLK = 1'b0;
  logic                       ARESETn;
  logic [ADDR_W-1:0]          AWADDR;
  logic                       AWVALID;
  logic                       AWREADY;
  logic [DATA_W-1:0]          WDATA;
  logic [3:0]                 WSTRB;
  logic                       WVALID;
  logic                       WREADY;
  logic [1:0]                 BRESP;
  logic                       BVALID;
  logic                       BREADY;
  logic [ADDR_W-1:0]          ARADDR;
  logic                       ARVALID;
  logic                       ARREADY;
  logic [DATA_W-1:0]          RDATA;
  logic [1:0]                 RRESP;
  logic                       RVALID;
  logic                       RREADY;
  logic [NUM_REGS*DATA_W-1:0] reg_q;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NUM_REGS];

  axil_regfile_slave #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .reg_q   (reg_q)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{strb[b]}};
`ifndef AXIL_WSTRB_EN
    mask = '1;
`endif
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Reference: index is the byte address divided by four; anything past the last register errors.
  task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
    int idx = int'(addr) / 4;
    if (idx >= NUM_REGS) resp = 2'b10;
    else begin
      model[idx] = merge_bytes(model[idx], data, strb);
      resp = 2'b00;
    end
  endtask

  task automatic model_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int idx = int'(addr) / 4;
    if (idx >= NUM_REGS) begin
      data = 32'h0;
      resp = 2'b10;
    end else begin
      data = model[idx];
      resp = 2'b00;
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  task automatic idle_inputs();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    ARVALID = 1'b0;
    BREADY  = 1'b1;
    RREADY  = 1'b1;
    AWADDR  = '0;
    WDATA   = '0;
    WSTRB   = 4'hF;
    ARADDR  = '0;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    int n = 0;
    logic aw_hs, w_hs;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    while ((AWVALID || WVALID) && n < 20) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      tick();
      n++;
      if (aw_hs) AWVALID = 1'b0;
      if (w_hs)  WVALID  = 1'b0;
    end
    n = 0;
    while (!BVALID && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (BVALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_timeout addr=%h got BVALID=%b want 1", addr, BVALID);
    end
    resp = BRESP;
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    logic ar_hs;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    while (ARVALID && n < 20) begin
      ar_hs = ARREADY;
      tick();
      n++;
      if (ar_hs) ARVALID = 1'b0;
    end
    checks++;
    if (RVALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_timeout addr=%h got RVALID=%b want 1", addr, RVALID);
    end
    data = RDATA;
    resp = RRESP;
    ARVALID = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESETn = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    tick(); tick();
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++; $display("[TB] FAIL reset_ready got %b want 111", {AWREADY, WREADY, ARREADY});
    end
    checks++;
    if ({BVALID, RVALID} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_valid got %b want 00", {BVALID, RVALID});
    end
    checks++;
    if ({BRESP, RRESP} !== 4'b0000 || RDATA !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_resp got %b/%h want 0000/0", {BRESP, RRESP}, RDATA);
    end
    checks++;
    if (reg_q !== '0) begin
      errors++; $display("[TB] FAIL reset_regs got %h want 0", reg_q);
    end
    ARESETn = 1'b1;
    tick();
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
      errors++; $display("[TB] FAIL post_reset got %b want 11100",
                         {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
  endtask

  task automatic test_write_read();
    logic [1:0] er, rr;
    logic [31:0] ed, rd;
    AWADDR = 8'h08; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    model_write(8'h08, 32'hDEADBEEF, 4'hF, er);
    checks++;
    if ({BVALID, BRESP} !== 3'b100) begin
      errors++; $display("[TB] FAIL wr_latency got %b want 100", {BVALID, BRESP});
    end
    checks++;
    if (reg_q[2*32 +: 32] !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL wr_reg2 got %h want deadbeef", reg_q[2*32 +: 32]);
    end
    tick();
    checks++;
    if (BVALID !== 1'b0) begin
      errors++; $display("[TB] FAIL wr_bclear got %b want 0", BVALID);
    end
    axi_read(8'h08, rd, rr);
    model_read(8'h08, ed, er);
    checks++;
    if (rd !== ed || rr !== er) begin
      errors++; $display("[TB] FAIL rd_0x08 got %h/%b want %h/%b", rd, rr, ed, er);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] er;
    logic [31:0] old1 = model[1];
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1; AWVALID = 1'b0;
    tick();
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (WREADY !== 1'b0 || BVALID !== 1'b0 || reg_q[1*32 +: 32] !== old1) begin
        errors++; $display("[TB] FAIL w_held cyc%0d got WREADY=%b BVALID=%b reg1=%h want 0 0 %h",
                           i, WREADY, BVALID, reg_q[1*32 +: 32], old1);
      end
      tick();
    end
    AWADDR = 8'h04; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    model_write(8'h04, 32'h12345678, 4'hF, er);
    checks++;
    if (reg_q[1*32 +: 32] !== model[1] || {BVALID, BRESP} !== 3'b100) begin
      errors++; $display("[TB] FAIL w_first_commit got reg1=%h B=%b want %h 100",
                         reg_q[1*32 +: 32], {BVALID, BRESP}, model[1]);
    end
    checks++;
    if ({AWREADY, WREADY} !== 2'b11) begin
      errors++; $display("[TB] FAIL w_first_ready got %b want 11", {AWREADY, WREADY});
    end
    tick();
  endtask

  task automatic test_slverr();
    logic [1:0] r, er;
    logic [31:0] d;
    axi_write(8'h40, $urandom, 4'hF, r);
    model_write(8'h40, 32'h0, 4'hF, er);
    checks++;
    if (r !== er || reg_q !== model_flat()) begin
      errors++; $display("[TB] FAIL slverr_wr got %b want %b regs_ok=%b", r, er, reg_q === model_flat());
    end
    axi_read(8'h40, d, r);
    checks++;
    if (r !== 2'b10 || d !== 32'h0) begin
      errors++; $display("[TB] FAIL slverr_rd got %b/%h want 10/0", r, d);
    end
  endtask

  task automatic test_random();
    logic [1:0] r, er;
    logic [31:0] d, ed;
    logic [7:0] a;
    logic [3:0] s;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom);
        axi_write(a, d, s, r);
        model_write(a, d, s, er);
        checks++;
        if (r !== er || reg_q !== model_flat()) begin
          errors++; $display("[TB] FAIL rand_wr%0d addr=%h got %b want %b regs_ok=%b",
                             i, a, r, er, reg_q === model_flat());
        end
      end else begin
        axi_read(a, d, r);
        model_read(a, ed, er);
        checks++;
        if (d !== ed || r !== er) begin
          errors++; $display("[TB] FAIL rand_rd%0d addr=%h got %h/%b want %h/%b", i, a, d, r, ed, er);
        end
      end
    end
  endtask

  task automatic test_simultaneous_rw();
    logic [1:0] er;
    logic [31:0] old5 = model[5];
    logic [31:0] nv = ~old5;
    AWADDR = 8'h14; WDATA = nv; WSTRB = 4'hF; ARADDR = 8'h14;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    model_write(8'h14, nv, 4'hF, er);
    checks++;
    if (RVALID !== 1'b1 || RDATA !== old5) begin
      errors++; $display("[TB] FAIL same_edge_rd got %b/%h want 1/%h", RVALID, RDATA, old5);
    end
    checks++;
    if (reg_q[5*32 +: 32] !== model[5]) begin
      errors++; $display("[TB] FAIL same_edge_wr got %h want %h", reg_q[5*32 +: 32], model[5]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] er;
    logic [31:0] ed;
    logic [7:0] a;
    ARVALID = 1'b1; RREADY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 79));
      ARADDR = a;
      checks++;
      if (ARREADY !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b_arready%0d got %b want 1", i, ARREADY);
      end
      tick();
      model_read(a, ed, er);
      checks++;
      if (RVALID !== 1'b1 || RDATA !== ed || RRESP !== er) begin
        errors++; $display("[TB] FAIL b2b_rd%0d addr=%h got %b/%h/%b want 1/%h/%b",
                           i, a, RVALID, RDATA, RRESP, ed, er);
      end
    end
    ARVALID = 1'b0;
    tick();
    checks++;
    if (RVALID !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_drain got %b want 0", RVALID);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] er;
    logic [31:0] d2 = $urandom;
    logic [31:0] old3 = model[3];
    BREADY = 1'b0;
    AWADDR = 8'h44; WDATA = $urandom; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    checks++;
    if ({BVALID, BRESP} !== 3'b110) begin
      errors++; $display("[TB] FAIL bp_first got %b want 110", {BVALID, BRESP});
    end
    AWADDR = 8'h0C; WDATA = d2;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({BVALID, BRESP} !== 3'b110 || {AWREADY, WREADY} !== 2'b00 || reg_q[3*32 +: 32] !== old3) begin
        errors++; $display("[TB] FAIL bp_hold%0d got B=%b rdy=%b reg3=%h want 110 00 %h",
                           i, {BVALID, BRESP}, {AWREADY, WREADY}, reg_q[3*32 +: 32], old3);
      end
      tick();
    end
    BREADY = 1'b1;
    tick();
    model_write(8'h0C, d2, 4'hF, er);
    checks++;
    if ({BVALID, BRESP} !== 3'b100 || reg_q[3*32 +: 32] !== model[3] || {AWREADY, WREADY} !== 2'b11) begin
      errors++; $display("[TB] FAIL bp_release got B=%b reg3=%h rdy=%b want 100 %h 11",
                         {BVALID, BRESP}, reg_q[3*32 +: 32], {AWREADY, WREADY}, model[3]);
    end
    tick();
    checks++;
    if (BVALID !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_bclear got %b want 0", BVALID);
    end
    RREADY = 1'b0; ARADDR = 8'h0C; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (RVALID !== 1'b1 || RDATA !== model[3] || RRESP !== 2'b00 || ARREADY !== 1'b0) begin
        errors++; $display("[TB] FAIL rbp_hold%0d got %b/%h/%b arready=%b want 1/%h/00 0",
                           i, RVALID, RDATA, RRESP, ARREADY, model[3]);
      end
      tick();
    end
    RREADY = 1'b1;
    tick();
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      errors++; $display("[TB] FAIL rbp_release got %b/%b want 0/1", RVALID, ARREADY);
    end
  endtask

  task automatic test_wstrb();
    logic [1:0] r, er;
    logic [31:0] want;
    logic [31:0] d = $urandom;
`ifdef AXIL_WSTRB_EN
    want = 32'hFF00FF00;
`else
    want = 32'h00000000;
`endif
    axi_write(8'h08, 32'hFFFFFFFF, 4'hF, r);
    model_write(8'h08, 32'hFFFFFFFF, 4'hF, er);
    axi_write(8'h08, 32'h00000000, 4'b0101, r);
    model_write(8'h08, 32'h00000000, 4'b0101, er);
    checks++;
    if (reg_q[2*32 +: 32] !== want || r !== 2'b00) begin
      errors++; $display("[TB] FAIL wstrb_0101 got %h/%b want %h/00", reg_q[2*32 +: 32], r, want);
    end
    axi_write(8'h08, d, 4'b0000, r);
    model_write(8'h08, d, 4'b0000, er);
    checks++;
    if (reg_q[2*32 +: 32] !== model[2] || r !== 2'b00) begin
      errors++; $display("[TB] FAIL wstrb_zero got %h/%b want %h/00", reg_q[2*32 +: 32], r, model[2]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] x = $urandom;
    WDATA = $urandom; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    ARESETn = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    #2;
    checks++;
    if (WREADY !== 1'b1 || reg_q !== '0 || BVALID !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset got WREADY=%b BVALID=%b regs_zero=%b want 1 0 1",
                         WREADY, BVALID, reg_q === '0);
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
    AWADDR = 8'h00; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    tick();
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b0 || reg_q !== '0) begin
      errors++; $display("[TB] FAIL mid_reset_dropped_w got BVALID=%b AWREADY=%b want 0 0", BVALID, AWREADY);
    end
    WDATA = x; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    checks++;
    if (BVALID !== 1'b1 || reg_q[31:0] !== x) begin
      errors++; $display("[TB] FAIL mid_reset_commit got %b/%h want 1/%h", BVALID, reg_q[31:0], x);
    end
    model[0] = x;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_slverr();
    test_random();
    test_simultaneous_rw();
    test_back_to_back();
    test_backpressure();
    test_wstrb();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
